branch_predictor: RTL and testbench

- Fetch-side companion to the execute-stage branch condition unit: predicts direction and target at fetch; the resolved outcome from execute trains it.
- Direct-mapped table of 2-bit saturating counters plus a tagged target buffer (BTB).
- Registered lookup, one-cycle latency. A registered mispredict flag feeds back to the PC mux and the flush logic.

---
 rtl/branch_predictor.sv | 171 +++++++++++++++++
 tb/tb_branch_predictor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: direct-mapped 2-bit counters plus tagged BTB,
// swept clean by an INIT pass after reset. Optional gshare indexing under BP_GSHARE_EN.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                f_req,
  input  logic [XLEN-1:0]     f_pc,
  output logic                f_pred_valid,
  output logic                f_pred_taken,
  output logic [XLEN-1:0]     f_pred_target,
  output logic [IDX_BITS-1:0] f_ghr,
  input  logic                u_valid,
  input  logic [XLEN-1:0]     u_pc,
  input  logic                u_taken,
  input  logic [XLEN-1:0]     u_target,
  input  logic                u_pred_taken,
  input  logic [XLEN-1:0]     u_pred_target,
  input  logic [IDX_BITS-1:0] u_ghr,
  output logic                u_mispredict,
  output logic [CNT_W-1:0]    mp_count
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t              state_q;
  logic [IDX_BITS-1:0] ptr_q;
  logic                ready_q;

  logic [ENTRIES-1:0]  tv_q;
  logic [TAG_W-1:0]    tt_q [ENTRIES];
  logic [XLEN-1:0]     tg_q [ENTRIES];
  logic [1:0]          tc_q [ENTRIES];

  logic                pv_q, pv_d, pt_q, pt_d, mp_q, mp_d;
  logic [XLEN-1:0]     ptg_q, ptg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_BITS-1:0] l_idx, u_idx, wr_idx;
  logic                wr_en, wr_valid, run, l_hit, u_hit;
  logic [TAG_W-1:0]    wr_tag;
  logic [XLEN-1:0]     wr_tgt;
  logic [1:0]          wr_cnt, u_c;

  logic unused_pc;
  assign unused_pc = ^{f_pc[1:0], u_pc[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d, fghr_q;
  assign l_idx = f_pc[IDX_BITS+1:2] ^ ghr_q;
  assign u_idx = u_pc[IDX_BITS+1:2] ^ u_ghr;
  assign f_ghr = fghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (!run)         ghr_d = '0;
    else if (u_valid) ghr_d = {ghr_q[IDX_BITS-2:0], u_taken};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q  <= '0;
      fghr_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      fghr_q <= ghr_q;
    end
  end
`else
  logic unused_ghr;
  assign unused_ghr = ^u_ghr;
  assign l_idx = f_pc[IDX_BITS+1:2];
  assign u_idx = u_pc[IDX_BITS+1:2];
  assign f_ghr = '0;
`endif

  assign run   = (state_q == S_RUN);
  assign l_hit = tv_q[l_idx] && (tt_q[l_idx] == f_pc[XLEN-1:IDX_BITS+2]);
  assign u_hit = tv_q[u_idx] && (tt_q[u_idx] == u_pc[XLEN-1:IDX_BITS+2]);
  assign u_c   = tc_q[u_idx];

  always_comb begin
    pv_d  = f_req;
    pt_d  = run && l_hit && tc_q[l_idx][1];
    ptg_d = pt_d ? tg_q[l_idx] : '0;
    mp_d  = run && u_valid &&
            ((u_pred_taken != u_taken) || (u_taken && (u_pred_target != u_target)));
    cnt_d = (mp_d && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    wr_en    = 1'b0;
    wr_idx   = u_idx;
    wr_valid = 1'b1;
    wr_tag   = u_pc[XLEN-1:IDX_BITS+2];
    wr_tgt   = u_target;
    wr_cnt   = 2'b10;
    if (!run) begin
      wr_en    = 1'b1;
      wr_idx   = ptr_q;
      wr_valid = 1'b0;
      wr_tag   = '0;
      wr_tgt   = '0;
      wr_cnt   = 2'b01;
    end else if (u_valid) begin
      if (u_hit) begin
        wr_en  = 1'b1;
        wr_tgt = u_taken ? u_target : tg_q[u_idx];
        if (u_taken) wr_cnt = (u_c == 2'b11) ? u_c : u_c + 2'd1;
        else         wr_cnt = (u_c == 2'b00) ? u_c : u_c - 2'd1;
      end else if (u_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  // Single write port; lookups read old contents in the same cycle.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      tv_q[wr_idx] <= wr_valid;
      tt_q[wr_idx] <= wr_tag;
      tg_q[wr_idx] <= wr_tgt;
      tc_q[wr_idx] <= wr_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (&ptr_q) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pv_q  <= 1'b0;
      pt_q  <= 1'b0;
      ptg_q <= '0;
      mp_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      pv_q  <= pv_d;
      pt_q  <= pt_d;
      ptg_q <= ptg_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
    end
  end

  assign ready         = ready_q;
  assign f_pred_valid  = pv_q;
  assign f_pred_taken  = pt_q;
  assign f_pred_target = ptg_q;
  assign u_mispredict  = mp_q;
  assign mp_count      = cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model compared every cycle.
module tb_branch_predictor;
  logic        clk = 0, rst;
  logic        ready, f_req, f_pred_valid, f_pred_taken;
  logic [31:0] f_pc, f_pred_target;
  logic [5:0]  f_ghr, u_ghr;
  logic        u_valid, u_taken, u_pred_taken, u_mispredict;
  logic [31:0] u_pc, u_target, u_pred_target;
  logic [15:0] mp_count;

  int total = 0, bad = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .ready(ready),
    .f_req(f_req), .f_pc(f_pc), .f_pred_valid(f_pred_valid), .f_pred_taken(f_pred_taken),
    .f_pred_target(f_pred_target), .f_ghr(f_ghr),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
    .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target), .u_ghr(u_ghr),
    .u_mispredict(u_mispredict), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain table of entries indexed by pc word address modulo 64.
  bit          m_v   [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int          m_cnt [64];
  bit          running = 0, seen_rst = 0;
  int          init_done = 0;
  bit          e_ready, e_pv, e_pt, e_mp;
  int unsigned e_tgt, e_cnt;

  always @(posedge clk) begin
    int i;
    if (!rst) begin
      seen_rst = 1; running = 0; init_done = 0;
      e_ready = 0; e_pv = 0; e_pt = 0; e_tgt = 0; e_mp = 0; e_cnt = 0;
    end else begin
      i = (f_pc / 4) % 64;
      e_pv  = f_req;
      e_pt  = running && m_v[i] && m_tag[i] == f_pc / 256 && m_cnt[i] >= 2;
      e_tgt = e_pt ? m_tgt[i] : 0;
      e_mp  = 0;
      if (running && u_valid) begin
        e_mp = (u_pred_taken != u_taken) || (u_taken && u_pred_target != u_target);
        if (e_mp && e_cnt < 65535) e_cnt++;
        i = (u_pc / 4) % 64;
        if (m_v[i] && m_tag[i] == u_pc / 256) begin
          if (u_taken) begin
            m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            m_tgt[i] = u_target;
          end else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end else if (u_taken) begin
          m_v[i] = 1; m_tag[i] = u_pc / 256; m_tgt[i] = u_target; m_cnt[i] = 2;
        end
      end
      if (!running) begin
        m_v[init_done] = 0; m_cnt[init_done] = 1; m_tgt[init_done] = 0;
        init_done++;
        if (init_done == 64) running = 1;
      end
      e_ready = running;
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      chk("ready", ready, e_ready);
      chk("f_pred_valid", f_pred_valid, e_pv);
      chk("f_pred_taken", f_pred_taken, e_pt);
      chk("f_pred_target", f_pred_target, e_tgt);
      chk("u_mispredict", u_mispredict, e_mp);
      chk("mp_count", mp_count, e_cnt);
      chk("f_ghr", f_ghr, 0);
    end
  end

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input bit ptk, input logic [31:0] ptgt);
    u_valid = 1; u_pc = pc; u_taken = tk; u_target = tgt;
    u_pred_taken = ptk; u_pred_target = ptgt;
    @(negedge clk);
    u_valid = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    f_req = 1; f_pc = pc;
    @(negedge clk);
    f_req = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 0; f_req = 0; f_pc = 0; u_valid = 0; u_pc = 0; u_taken = 0; u_target = 0;
    u_pred_taken = 0; u_pred_target = 0; u_ghr = 6'h2a;
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_mp_count", mp_count, 0);
    rst = 1;
    // Lookup during INIT: valid follows request, never predicts taken.
    @(negedge clk); @(negedge clk);
    f_req = 1; f_pc = 32'h100;
    @(negedge clk);
    f_req = 0;
    chk("init_lookup_valid", f_pred_valid, 1);
    chk("init_lookup_taken", f_pred_taken, 0);
    wait_ready(n);
    chk("init_cycles", n + 3, 64);

    upd(32'h100, 1, 32'h80, 0, 0);
    chk("first_alloc_mp", u_mispredict, 1);
    chk("first_alloc_cnt", mp_count, 1);
    look(32'h100);
    chk("alloc_taken", f_pred_taken, 1);
    chk("alloc_target", f_pred_target, 32'h80);

    repeat (3) upd(32'h100, 1, 32'h80, 1, 32'h80);
    chk("correct_no_mp", u_mispredict, 0);
    repeat (4) upd(32'h100, 0, 32'h0, 1, 32'h80);
    look(32'h100);
    chk("trained_nt", f_pred_taken, 0);
    chk("trained_nt_tgt", f_pred_target, 0);

    upd(32'h200, 1, 32'h44, 0, 0);
    look(32'h100);
    chk("alias_old_nt", f_pred_taken, 0);
    look(32'h200);
    chk("alias_new_taken", f_pred_taken, 1);
    chk("alias_new_tgt", f_pred_target, 32'h44);

    upd(32'h100, 1, 32'h80, 0, 0);
    f_req = 1; f_pc = 32'h100;
    upd(32'h100, 1, 32'h90, 1, 32'h80);
    f_req = 0;
    chk("wrong_tgt_mp", u_mispredict, 1);
    chk("rbw_old_tgt", f_pred_target, 32'h80);
    look(32'h100);
    chk("new_tgt", f_pred_target, 32'h90);

    u_valid = 1; u_pc = 32'h300; u_taken = 0; u_pred_taken = 1;
    repeat (65535 + 3) @(negedge clk);
    u_valid = 0;
    @(negedge clk);
    chk("mp_saturated", mp_count, 16'hffff);

    rst = 0;
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_mp_count", mp_count, 0);
    chk("rst_pred_target", f_pred_target, 0);
    rst = 1;
    wait_ready(n);
    chk("reinit_cycles", n, 64);
    look(32'h200);
    chk("reinit_gone", f_pred_taken, 0);
    look(32'h100);
    chk("reinit_gone2", f_pred_target, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
